// File: rtl/alu_issue_seq.sv
// Command sequencer for an external single-cycle ALU: accepts a command, issues it, waits for
// the result (with timeout) and holds the result until the downstream consumer takes it.
module alu_issue_seq #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_ctl,
  input  logic       cmd_cin,
  input  logic       cmd_chain,
  output logic       valid_in,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       cin,
  output logic [3:0] ctl,
  input  logic       valid_out,
  input  logic [3:0] alu,
  input  logic       carry,
  input  logic       zero,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_carry,
  output logic       res_zero,
  output logic       res_err,
  output logic [7:0] op_count,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e     state_q;
  logic [3:0] wait_cnt_q;
  logic [3:0] acc_q;
  logic       carry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cmd_ready  <= 1'b1;
      valid_in   <= 1'b0;
      a          <= '0;
      b          <= '0;
      cin        <= 1'b0;
      ctl        <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_carry  <= 1'b0;
      res_zero   <= 1'b0;
      res_err    <= 1'b0;
      op_count   <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_ctl <= 4'd13) begin
              // Operands are latched here and stay on the ALU port until the op completes.
              a        <= cmd_chain ? acc_q : cmd_a;
              cin      <= cmd_chain ? carry_q : cmd_cin;
              b        <= cmd_b;
              ctl      <= cmd_ctl;
              valid_in <= 1'b1;
              state_q  <= StIssue;
            end else begin
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_data  <= '0;
              res_carry <= 1'b0;
              res_zero  <= 1'b0;
              state_q   <= StHold;
            end
          end
        end
        StIssue: begin
          valid_in   <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (valid_out) begin
            res_valid <= 1'b1;
            res_err   <= 1'b0;
            res_data  <= alu;
            res_carry <= carry;
            res_zero  <= zero;
            acc_q     <= alu;
            carry_q   <= carry;
            op_count  <= op_count + 8'd1;
            state_q   <= StHold;
          end else if (wait_cnt_q == 4'(TIMEOUT - 1)) begin
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            state_q   <= StHold;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        StHold: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: ALU stub, directed protocol cases, randomized commands vs. a
// transaction-level model of accumulator, carry and operation count.
module tb_alu_issue_seq;
  localparam int unsigned TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_ctl;
  logic       cmd_cin, cmd_chain;
  logic       valid_in;
  logic [3:0] a, b, ctl;
  logic       cin;
  logic       valid_out = 1'b0;
  logic [3:0] alu = '0;
  logic       carry = 1'b0, zero = 1'b0;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic       res_carry, res_zero, res_err;
  logic [7:0] op_count;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic       stub_en = 1'b1;
  logic       inject  = 1'b0;
  logic [4:0] stub_r;

  // Transaction-level model state
  logic [3:0] m_acc   = '0;
  logic       m_carry = 1'b0;
  logic [7:0] m_count = '0;

  alu_issue_seq #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_ctl   (cmd_ctl),
    .cmd_cin   (cmd_cin),
    .cmd_chain (cmd_chain),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .ctl       (ctl),
    .valid_out (valid_out),
    .alu       (alu),
    .carry     (carry),
    .zero      (zero),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_zero  (res_zero),
    .res_err   (res_err),
    .op_count  (op_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] stub_alu(input logic [3:0] c, input logic [3:0] x,
                                          input logic [3:0] y, input logic ci);
    case (c)
      4'd3:    return {1'b0, x} + {1'b0, y};
      4'd4:    return {1'b0, x} + {1'b0, y} + {4'd0, ci};
      default: return {1'b0, x ^ y ^ c};
    endcase
  endfunction

  // ALU stub: answers one cycle after valid_in; inject forces a stray valid_out.
  always_comb stub_r = stub_alu(ctl, a, b, cin);
  always @(posedge clk) begin
    valid_out <= (valid_in && stub_en) || inject;
    alu       <= stub_r[3:0];
    carry     <= stub_r[4];
    zero      <= (stub_r[3:0] == 4'd0);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [3:0] c, input logic [3:0] ta, input logic [3:0] tb,
                         input logic tcin, input logic tch, input logic respond, input int hold);
    logic [3:0] ea;
    logic       ecin;
    logic [4:0] r;
    logic [3:0] saved;
    @(negedge clk);
    chk("cmd_ready_idle", 8'(cmd_ready), 8'd1);
    cmd_valid = 1'b1; cmd_ctl = c; cmd_a = ta; cmd_b = tb; cmd_cin = tcin; cmd_chain = tch;
    res_ready = 1'b0; stub_en = respond;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (c > 4'd13) begin
      chk("illegal_no_valid_in", 8'(valid_in), 8'd0);
      chk("illegal_res_valid", 8'(res_valid), 8'd1);
      chk("illegal_res_err", 8'(res_err), 8'd1);
      chk("illegal_res_data", 8'(res_data), 8'd0);
      chk("illegal_flags", {6'd0, res_carry, res_zero}, 8'd0);
    end else begin
      ea   = tch ? m_acc : ta;
      ecin = tch ? m_carry : tcin;
      chk("issue_valid_in", 8'(valid_in), 8'd1);
      chk("issue_a", 8'(a), 8'(ea));
      chk("issue_b", 8'(b), 8'(tb));
      chk("issue_cin", 8'(cin), 8'(ecin));
      chk("issue_ctl", 8'(ctl), 8'(c));
      @(negedge clk);
      chk("wait_valid_in_low", 8'(valid_in), 8'd0);
      chk("wait_a_held", 8'(a), 8'(ea));
      if (respond) begin
        @(negedge clk);
        r = stub_alu(c, ea, tb, ecin);
        chk("res_valid", 8'(res_valid), 8'd1);
        chk("res_data", 8'(res_data), 8'(r[3:0]));
        chk("res_carry", 8'(res_carry), 8'(r[4]));
        chk("res_zero", 8'(res_zero), 8'(r[3:0] == 4'd0));
        chk("res_err", 8'(res_err), 8'd0);
        m_acc = r[3:0]; m_carry = r[4]; m_count = m_count + 8'd1;
      end else begin
        repeat (TIMEOUT - 1) begin
          @(negedge clk);
          chk("timeout_pending", 8'(res_valid), 8'd0);
        end
        @(negedge clk);
        chk("timeout_res_valid", 8'(res_valid), 8'd1);
        chk("timeout_res_err", 8'(res_err), 8'd1);
        chk("timeout_res_data", 8'(res_data), 8'd0);
        chk("timeout_flags", {6'd0, res_carry, res_zero}, 8'd0);
      end
    end
    chk("op_count", op_count, m_count);
    chk("busy_hold", 8'(busy), 8'd1);
    chk("cmd_ready_hold", 8'(cmd_ready), 8'd0);
    saved = res_data;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("stall_res_valid", 8'(res_valid), 8'd1);
      chk("stall_res_data", 8'(res_data), 8'(saved));
      chk("stall_cmd_ready", 8'(cmd_ready), 8'd0);
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("release_cmd_ready", 8'(cmd_ready), 8'd1);
    chk("release_res_valid", 8'(res_valid), 8'd0);
    chk("release_busy", 8'(busy), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_ctl = '0;
    cmd_cin = 1'b0; cmd_chain = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 8'(cmd_ready), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_res_valid", 8'(res_valid), 8'd0);
    chk("rst_valid_in", 8'(valid_in), 8'd0);
    chk("rst_op_count", op_count, 8'd0);
    reset = 1'b0;

    // Basic ADD, then overflowing ADD followed by a chained ADD with carry
    run_cmd(4'd3, 4'd9, 4'd8, 1'b0, 1'b0, 1'b1, 0);
    run_cmd(4'd3, 4'hF, 4'h1, 1'b0, 1'b0, 1'b1, 0);
    run_cmd(4'd4, 4'd7, 4'd2, 1'b0, 1'b1, 1'b1, 0);
    chk("chain_op_count", op_count, 8'd3);

    // Illegal opcode, timeout followed by a chained op, and a stalled consumer
    run_cmd(4'd14, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 0);
    run_cmd(4'd3, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 0);
    run_cmd(4'd4, 4'd0, 4'd1, 1'b0, 1'b1, 1'b1, 0);
    run_cmd(4'd6, 4'd3, 4'd9, 1'b1, 1'b0, 1'b1, 5);

    // Stray valid_out while idle must not count or capture
    @(negedge clk); inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    @(negedge clk);
    chk("stray_op_count", op_count, m_count);
    chk("stray_res_valid", 8'(res_valid), 8'd0);

    for (int n = 0; n < 40; n++) begin
      run_cmd(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 1'($urandom),
              1'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
    end

    // Reset while waiting; the late valid_out must be ignored
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ctl = 4'd3; cmd_a = 4'd5; cmd_b = 4'd6; cmd_chain = 1'b0;
    stub_en = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); reset = 1'b1; inject = 1'b1;
    @(negedge clk); reset = 1'b0; inject = 1'b0;
    @(negedge clk);
    chk("midwait_rst_cmd_ready", 8'(cmd_ready), 8'd1);
    chk("midwait_rst_res_valid", 8'(res_valid), 8'd0);
    chk("midwait_rst_op_count", op_count, 8'd0);
    chk("midwait_rst_busy", 8'(busy), 8'd0);
    chk("midwait_rst_res_data", 8'(res_data), 8'd0);
    m_acc = '0; m_carry = 1'b0; m_count = '0;
    run_cmd(4'd4, 4'd9, 4'd7, 1'b1, 1'b1, 1'b1, 0);

    // Reset beats a simultaneous command handshake
    @(negedge clk); cmd_valid = 1'b1; cmd_ctl = 4'd3; reset = 1'b1;
    @(negedge clk); cmd_valid = 1'b0; reset = 1'b0;
    chk("rst_prio_cmd_ready", 8'(cmd_ready), 8'd1);
    chk("rst_prio_busy", 8'(busy), 8'd0);
    chk("rst_prio_valid_in", 8'(valid_in), 8'd0);
    chk("rst_prio_op_count", op_count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
